// File: rtl/sdram_pattern_tester.sv
// SDRAM pattern tester: after power-up wait, writes WORD_COUNT seeded-pattern words and reads them back, counting mismatches.
// One request outstanding at a time (req pulse, wait for ack); a WAIT state without ack for TIMEOUT_CYCLES aborts to DONE.
module sdram_pattern_tester #(
    parameter int                ADDR_W         = 24,
    parameter int                DATA_W         = 16,
    parameter int                INIT_CYCLES    = 25000,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                WORD_COUNT     = 256,
    parameter int                TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] seed,
    output logic              sdram_req,
    input  logic              sdram_ack,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_rh_wl,
    output logic [DATA_W-1:0] sdram_data_w,
    input  logic [DATA_W-1:0] sdram_data_r,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE
    } state_t;

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORD_COUNT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [INIT_W-1:0]   r_init_cnt;
    logic [TMO_W-1:0]    r_wait_cnt;
    logic [ADDR_W-1:0]   r_idx;
    logic [1:0]          r_mode;
    logic [DATA_W-1:0]   r_seed;
    logic [15:0]         r_err_cnt;
    logic [ADDR_W-1:0]   r_first_err;
    logic                r_timeout;

    logic                w_accept;
    logic                w_wait;
    logic                w_wr_phase;
    logic                w_last;
    logic                w_init_end;
    logic                w_tmo;
    logic                w_mismatch;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_idx_d;
    logic [DATA_W-1:0]   w_walk;
    logic [DATA_W-1:0]   w_pattern;

    assign w_accept   = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_wait     = (r_state == S_WR_WAIT) || (r_state == S_RD_WAIT);
    assign w_wr_phase = (r_state == S_WR_REQ) || (r_state == S_WR_WAIT);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_init_end = (r_init_cnt == INIT_W'(INIT_CYCLES - 1));
    assign w_tmo      = w_wait && !sdram_ack && (r_wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_addr     = BASE_ADDR + r_idx;

    // The same generator serves both phases, so the read compare sees exactly what was written.
    assign w_idx_d = DATA_W'(r_idx);
    assign w_walk  = DATA_W'(1) << (r_idx % ADDR_W'(DATA_W));

    always_comb begin
        w_pattern = r_seed;
        case (r_mode)
            2'd0:    w_pattern = r_seed;
            2'd1:    w_pattern = w_idx_d ^ r_seed;
            2'd2:    w_pattern = w_walk;
            default: w_pattern = ~(w_idx_d ^ r_seed);
        endcase
    end

    assign w_mismatch = (r_state == S_RD_WAIT) && sdram_ack && (sdram_data_r != w_pattern);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:    if (w_init_end) w_next = S_IDLE;
            S_IDLE,
            S_DONE:    if (start) w_next = S_WR_REQ;
            S_WR_REQ:  w_next = S_WR_WAIT;
            S_WR_WAIT: begin
                if (sdram_ack)  w_next = w_last ? S_RD_REQ : S_WR_REQ;
                else if (w_tmo) w_next = S_DONE;
            end
            S_RD_REQ:  w_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (sdram_ack)  w_next = w_last ? S_DONE : S_RD_REQ;
                else if (w_tmo) w_next = S_DONE;
            end
            default:   w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_init_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_idx       <= '0;
            r_mode      <= '0;
            r_seed      <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (r_state == S_INIT && !w_init_end) begin
                r_init_cnt <= r_init_cnt + INIT_W'(1);
            end

            // Cleared in every non-WAIT cycle, so each WAIT starts counting from zero.
            if (w_wait) begin
                r_wait_cnt <= r_wait_cnt + TMO_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end

            if (w_accept) begin
                r_idx       <= '0;
                r_mode      <= pattern_sel;
                r_seed      <= seed;
                r_err_cnt   <= '0;
                r_first_err <= '0;
                r_timeout   <= 1'b0;
            end

            if (r_state == S_WR_WAIT && sdram_ack) begin
                r_idx <= w_last ? '0 : r_idx + ADDR_W'(1);
            end
            if (r_state == S_RD_WAIT && sdram_ack && !w_last) begin
                r_idx <= r_idx + ADDR_W'(1);
            end

            if (w_mismatch) begin
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
                if (r_err_cnt == 16'd0) begin
                    r_first_err <= w_addr;
                end
            end

            if (w_tmo) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign busy           = (r_state == S_WR_REQ) || (r_state == S_WR_WAIT) ||
                            (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
    assign done           = (r_state == S_DONE);
    assign pass           = done && (r_err_cnt == 16'd0) && !r_timeout;
    assign timeout        = r_timeout;
    assign err_count      = r_err_cnt;
    assign first_err_addr = r_first_err;

    // Request fields are pure functions of the held index, so they stay stable until the ack.
    assign sdram_req    = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);
    assign sdram_addr   = busy ? w_addr : '0;
    assign sdram_rh_wl  = !w_wr_phase;
    assign sdram_data_w = w_wr_phase ? w_pattern : '0;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: a behavioural SDRAM controller with random ack latency plus a spec-level pattern model.
module tb_sdram_pattern_tester;

    localparam int          INIT = 20;
    localparam int          WC   = 18;
    localparam int          TMO  = 16;
    localparam logic [23:0] BASE = 24'hFFFFF8;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] seed = 16'h0;
    logic        sdram_req;
    logic        sdram_ack = 1'b0;
    logic [23:0] sdram_addr;
    logic        sdram_rh_wl;
    logic [15:0] sdram_data_w;
    logic [15:0] sdram_data_r = 16'h0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [23:0] first_err_addr;

    sdram_pattern_tester #(
        .ADDR_W(24), .DATA_W(16), .INIT_CYCLES(INIT), .BASE_ADDR(BASE),
        .WORD_COUNT(WC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_l(reset_l), .start(start), .pattern_sel(pattern_sel), .seed(seed),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
        .sdram_rh_wl(sdram_rh_wl), .sdram_data_w(sdram_data_w), .sdram_data_r(sdram_data_r),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
    } rec_t;

    rec_t        wr_q[$];
    rec_t        rd_q[$];
    logic [15:0] mem[logic [23:0]];
    int          checks = 0;
    int          errors = 0;

    // Controller model knobs and state
    int          pend = 0;
    int          stab_err = 0;
    int          dly_lo = 3;
    int          dly_hi = 3;
    int          drop_wr = -1;
    bit          spur = 1'b0;
    bit          corrupt = 1'b0;
    logic [23:0] bad_a0 = 24'h0;
    logic [23:0] bad_a1 = 24'h0;
    logic [23:0] cur_addr = 24'h0;
    logic        cur_rd = 1'b0;
    logic [15:0] cur_data = 16'h0;

    always @(negedge clk) begin
        if (!reset_l) begin
            pend = 0;
            sdram_ack = 1'b0;
        end else begin
            sdram_ack = 1'b0;
            sdram_data_r = 16'($urandom);
            if (pend > 0) begin
                if (sdram_addr !== cur_addr || sdram_rh_wl !== cur_rd ||
                    (!cur_rd && sdram_data_w !== cur_data))
                    stab_err++;
                pend--;
                if (pend == 0) begin
                    sdram_ack = 1'b1;
                    if (cur_rd) begin
                        sdram_data_r = mem.exists(cur_addr) ? mem[cur_addr] : 16'h0;
                        if (corrupt && (cur_addr == bad_a0 || cur_addr == bad_a1))
                            sdram_data_r = 16'h0000;
                    end else begin
                        mem[cur_addr] = cur_data;
                    end
                end
            end
            if (sdram_req === 1'b1) begin
                if (pend != 0) stab_err++;
                cur_addr = sdram_addr;
                cur_rd   = sdram_rh_wl;
                cur_data = sdram_data_w;
                if (cur_rd) rd_q.push_back({cur_addr, 16'h0});
                else        wr_q.push_back({cur_addr, cur_data});
                if (!cur_rd && int'(wr_q.size()) == drop_wr + 1) pend = 0;
                else pend = int'($urandom_range(dly_hi, dly_lo));
                if (spur) sdram_ack = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_data(input int mode, input logic [15:0] s, input int i);
        logic [15:0] iv;
        iv = 16'(i);
        case (mode)
            0:       return s;
            1:       return iv ^ s;
            2:       return 16'(1) << (i % 16);
            default: return ~(iv ^ s);
        endcase
    endfunction

    function automatic logic [23:0] exp_addr(input int i);
        logic [31:0] a;
        a = {8'h0, BASE} + 32'(i);
        return a[23:0];
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_pass(input logic [1:0] m, input logic [15:0] s);
        wr_q.delete();
        rd_q.delete();
        tick();
        pattern_sel = m;
        seed = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int  n;
        int  first_busy;
        bit  ok;
        reset_l = 1'b0;
        repeat (3) tick();
        checks++;
        if ({sdram_req, sdram_rh_wl, sdram_addr, sdram_data_w, busy, done, pass, timeout, err_count, first_err_addr}
            !== {1'b0, 1'b1, 24'h0, 16'h0, 4'b0000, 16'h0, 24'h0})
            begin errors++; $display("FAIL reset_vals: req=%b rh=%b addr=%h dw=%h busy=%b done=%b pass=%b to=%b err=%h first=%h, want 0 1 0 0 0 0 0 0 0 0",
                sdram_req, sdram_rh_wl, sdram_addr, sdram_data_w, busy, done, pass, timeout, err_count, first_err_addr); end

        // Pulse start inside INIT, then hold it from cycle 10: first acceptance must wait for INIT to expire.
        pattern_sel = 2'd1;
        seed = 16'hF055;
        dly_lo = 3;
        dly_hi = 3;
        wr_q.delete();
        rd_q.delete();
        reset_l = 1'b1;
        first_busy = -1;
        for (n = 1; n <= 60; n++) begin
            tick();
            if (busy === 1'b1) begin
                first_busy = n;
                break;
            end
            start = (n == 5 || n >= 10);
        end
        start = 1'b0;
        checks++;
        if (first_busy != INIT + 1)
            begin errors++; $display("FAIL init_len: first busy cycle %0d, want %0d", first_busy, INIT + 1); end

        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL init_pass_done: done never seen, want 1"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_q.size() <= i || wr_q[i] !== {exp_addr(i), exp_data(1, 16'hF055, i)})
                begin errors++; $display("FAIL ideal_wr%0d: got %h, want %h", i,
                    (wr_q.size() > i) ? wr_q[i] : 40'h0, {exp_addr(i), exp_data(1, 16'hF055, i)}); end
        end
        checks++;
        if ({done, pass, timeout, err_count} !== {1'b1, 1'b1, 1'b0, 16'h0})
            begin errors++; $display("FAIL ideal_status: done=%b pass=%b to=%b err=%0d, want 1 1 0 0", done, pass, timeout, err_count); end
    endtask

    task automatic test_random_patterns();
        logic [1:0]  m;
        logic [15:0] s;
        bit          ok;
        dly_lo = 1;
        dly_hi = 5;
        for (int p = 0; p < 4; p++) begin
            m = 2'(p);
            s = 16'($urandom);
            start_pass(m, s);
            if (p == 1) begin
                // A start pulse while waiting on a write ack must not restart the pass.
                for (int k = 0; k < 200 && wr_q.size() < 4; k++) tick();
                tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            wait_done(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand%0d_done: done never seen, want 1", p); end
            checks++;
            if (wr_q.size() != WC || rd_q.size() != WC)
                begin errors++; $display("FAIL rand%0d_count: writes=%0d reads=%0d, want %0d each", p, wr_q.size(), rd_q.size(), WC); end
            for (int i = 0; i < WC && i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== {exp_addr(i), exp_data(int'(m), s, i)})
                    begin errors++; $display("FAIL rand%0d_wr%0d: got %h, want %h", p, i, wr_q[i], {exp_addr(i), exp_data(int'(m), s, i)}); end
            end
            for (int i = 0; i < WC && i < rd_q.size(); i++) begin
                checks++;
                if (rd_q[i].addr !== exp_addr(i))
                    begin errors++; $display("FAIL rand%0d_rd%0d: got addr %h, want %h", p, i, rd_q[i].addr, exp_addr(i)); end
            end
            checks++;
            if ({done, pass, timeout, err_count, busy} !== {1'b1, 1'b1, 1'b0, 16'h0, 1'b0})
                begin errors++; $display("FAIL rand%0d_status: done=%b pass=%b to=%b err=%0d busy=%b, want 1 1 0 0 0", p, done, pass, timeout, err_count, busy); end
            checks++;
            if (stab_err != 0)
                begin errors++; $display("FAIL rand%0d_stable: %0d protocol violations, want 0", p, stab_err); end
        end
    endtask

    task automatic test_walking_one();
        bit          ok;
        logic [15:0] w;
        spur = 1'b1;
        start_pass(2'd2, 16'($urandom));
        wait_done(ok);
        spur = 1'b0;
        checks++;
        if (!ok || wr_q.size() != WC)
            begin errors++; $display("FAIL walk_count: done=%b writes=%0d, want 1 %0d", ok, wr_q.size(), WC); end
        for (int i = 0; i < WC && i < wr_q.size(); i++) begin
            w = 16'h0001 << (i % 16);
            checks++;
            if (wr_q[i].data !== w)
                begin errors++; $display("FAIL walk_wr%0d: got %h, want %h", i, wr_q[i].data, w); end
        end
        checks++;
        if ({pass, stab_err} !== {1'b1, 32'd0})
            begin errors++; $display("FAIL walk_status: pass=%b violations=%0d, want 1 0", pass, stab_err); end
    endtask

    task automatic test_mismatch();
        bit ok;
        corrupt = 1'b1;
        bad_a0 = exp_addr(5);
        bad_a1 = exp_addr(12);
        start_pass(2'd2, 16'h0);
        wait_done(ok);
        corrupt = 1'b0;
        checks++;
        if (!ok || rd_q.size() != WC)
            begin errors++; $display("FAIL mism_count: done=%b reads=%0d, want 1 %0d", ok, rd_q.size(), WC); end
        checks++;
        if ({err_count, first_err_addr, pass, done, timeout} !== {16'd2, exp_addr(5), 1'b0, 1'b1, 1'b0})
            begin errors++; $display("FAIL mism_status: err=%0d first=%h pass=%b done=%b to=%b, want 2 %h 0 1 0",
                err_count, first_err_addr, pass, done, timeout, exp_addr(5)); end
    endtask

    task automatic test_back_to_back();
        bit          ok;
        logic [15:0] s;
        s = 16'($urandom);
        start_pass(2'd0, s);
        checks++;
        if ({busy, done, pass, timeout, err_count, first_err_addr} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 24'h0})
            begin errors++; $display("FAIL b2b_clear: busy=%b done=%b pass=%b to=%b err=%0d first=%h, want 1 0 0 0 0 0",
                busy, done, pass, timeout, err_count, first_err_addr); end
        wait_done(ok);
        checks++;
        if (!ok || wr_q.size() != WC || pass !== 1'b1)
            begin errors++; $display("FAIL b2b_rerun: done=%b writes=%0d pass=%b, want 1 %0d 1", ok, wr_q.size(), pass, WC); end
        for (int i = 0; i < WC && i < wr_q.size(); i += 7) begin
            checks++;
            if (wr_q[i].data !== s)
                begin errors++; $display("FAIL b2b_wr%0d: got %h, want %h", i, wr_q[i].data, s); end
        end
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        drop_wr = 2;
        start_pass(2'd3, 16'($urandom));
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (wr_q.size() == 3) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done === 1'b1) break;
            if (busy === 1'b1) n++;
        end
        drop_wr = -1;
        checks++;
        if (!seen || n != TMO)
            begin errors++; $display("FAIL tmo_wait: third write seen=%b wait cycles=%0d, want 1 %0d", seen, n, TMO); end
        checks++;
        if ({timeout, done, pass, busy} !== 4'b1100)
            begin errors++; $display("FAIL tmo_status: to=%b done=%b pass=%b busy=%b, want 1 1 0 0", timeout, done, pass, busy); end
        repeat (5) tick();
        checks++;
        if (rd_q.size() != 0 || wr_q.size() != 3)
            begin errors++; $display("FAIL tmo_reqs: reads=%0d writes=%0d, want 0 3", rd_q.size(), wr_q.size()); end
    endtask

    task automatic test_reset_mid_pass();
        int  nreq;
        int  first_busy;
        bit  ok;
        start_pass(2'd1, 16'($urandom));
        for (int k = 0; k < 500 && rd_q.size() < 3; k++) tick();
        tick();
        checks++;
        if ({busy, sdram_rh_wl, sdram_req} !== 3'b110)
            begin errors++; $display("FAIL rst_pre: busy=%b rh=%b req=%b, want 1 1 0", busy, sdram_rh_wl, sdram_req); end
        reset_l = 1'b0;
        #1;
        checks++;
        if ({sdram_req, sdram_rh_wl, sdram_addr, sdram_data_w, busy, done, pass, timeout, err_count, first_err_addr}
            !== {1'b0, 1'b1, 24'h0, 16'h0, 4'b0000, 16'h0, 24'h0})
            begin errors++; $display("FAIL rst_mid_vals: req=%b rh=%b addr=%h dw=%h busy=%b done=%b pass=%b to=%b err=%h first=%h, want 0 1 0 0 0 0 0 0 0 0",
                sdram_req, sdram_rh_wl, sdram_addr, sdram_data_w, busy, done, pass, timeout, err_count, first_err_addr); end
        nreq = int'(wr_q.size() + rd_q.size());
        repeat (4) tick();
        pattern_sel = 2'd3;
        seed = 16'h1234;
        wr_q.delete();
        rd_q.delete();
        reset_l = 1'b1;
        first_busy = -1;
        start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (busy === 1'b1) begin
                first_busy = n;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (nreq < 3 || first_busy != INIT + 1)
            begin errors++; $display("FAIL rst_restart: first busy cycle %0d, want %0d", first_busy, INIT + 1); end
        wait_done(ok);
        checks++;
        if (!ok || pass !== 1'b1 || wr_q.size() != WC || wr_q[WC-1] !== {exp_addr(WC-1), exp_data(3, 16'h1234, WC-1)})
            begin errors++; $display("FAIL rst_recover: done=%b pass=%b writes=%0d, want 1 1 %0d", ok, pass, wr_q.size(), WC); end
    endtask

    initial begin
        test_reset();
        test_random_patterns();
        test_walking_one();
        test_mismatch();
        test_back_to_back();
        test_timeout();
        test_reset_mid_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
